orv64_mem_arbiter: RTL and testbench
====================================

# orv64_mem_arbiter

Single-outstanding arbiter sharing one 64-bit memory port among three requesters: instruction fetch (IF), data read (DR) and data write (DW). It sits between the orv64 fetch/LSU front ends and the memory model port (pc/inst, data_r*, data_w* style, 1-cycle access, per-cycle miss flag). It grants round-robin, aligns addresses, retries while the memory reports a miss, and returns one registered response per accepted request.

## Interface
- `MAX_RETRY`, default 16: consecutive miss cycles tolerated before aborting with error.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req_valid` in 1, `if_req_pc` in 64, `if_req_ready` out 1: fetch request.
- `if_resp_valid` out 1, `if_resp_inst` out 32, `if_resp_err` out 1: fetch response.
- `dr_req_valid` in 1, `dr_req_addr` in 64, `dr_req_ready` out 1: data read request.
- `dr_resp_valid` out 1, `dr_resp_rdata` out 64, `dr_resp_err` out 1: data read response.
- `dw_req_valid` in 1, `dw_req_addr` in 64, `dw_req_wdata` in 64, `dw_req_wmask` in 8, `dw_req_ready` out 1: data write request.
- `dw_resp_valid` out 1, `dw_resp_err` out 1: write acknowledge.
- `mem_re` out 1, `mem_raddr` out 64, `mem_rdata` in 64, `mem_rmiss` in 1: memory read side.
- `mem_we` out 1, `mem_waddr` out 64, `mem_wdata` out 64, `mem_wmask` out 8, `mem_wmiss` in 1: memory write side.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ERR.
- IDLE: if any req_valid, pick winner; assert that requester's ready (combinational, only in IDLE); latch source, address, wdata, wmask. Aligned -> ISSUE; misaligned (IF `pc[1:0]!=0`, DR/DW `addr[2:0]!=0`) -> ERR.
- ISSUE: drive `mem_re` (IF/DR) or `mem_we` (DW) = 1 with latched address `{addr[63:3],3'b0}`; retry counter cleared; -> WAIT.
- WAIT: keep driving same request; sample `mem_rmiss` (reads) / `mem_wmiss` (writes). Miss=0 -> register response, -> IDLE. Miss=1 -> counter++; when counter reaches `MAX_RETRY` -> error response, -> IDLE; else stay.
- ERR: register error response, no memory access, -> IDLE.
- Response: one-cycle valid pulse on owner's channel only. IF data = `pc[2] ? mem_rdata[63:32] : mem_rdata[31:0]`. Data fields are 0 whenever err=1.
- Round-robin: cyclic order IF(0), DR(1), DW(2); pointer marks highest priority; after grant k, pointer = (k+1) mod 3. Reset pointer = DW.
- Repeated write cycles in WAIT rewrite identical data/mask (idempotent).
- Requests arriving while not IDLE are held by the requester (ready=0); no queueing.

## Timing
- Hit: ready at cycle N, ISSUE N+1, WAIT N+2 sees miss=0, resp_valid N+3, next grant possible N+3.
- Each miss cycle adds 1 cycle; abort at WAIT cycle `MAX_RETRY`, error resp the following cycle.
- Misaligned: ready N, ERR N+1, resp_valid/err N+2.
- Reset (asynchronous, any state): state IDLE, pointer DW, counter 0; all ready/resp_valid/err, `mem_re`, `mem_we` = 0; all data/address outputs 0. An in-flight request produces no response.
- Response and next grant may coincide in the same cycle.

## Structure
- `orv64_typedef_pkg`: `orv64_marb_src_e` (IF/DR/DW), `orv64_marb_state_e`, `orv64_marb_req_t` (src, addr, wdata, wmask).
- `orv64_param_pkg`: default `MAX_RETRY`.
- Sub-module `orv64_rr_arb3`: 3-way round-robin pick (valid vector + pointer -> one-hot grant), combinational.

## Test plan
- IF pc=0x1004 alone, memory hit, word 0x1000 = 0xDEADBEEF_00000013 -> if_resp_valid at N+3, inst=0xDEADBEEF, err=0.
- All three valid continuously after reset -> grant order DW, IF, DR, DW, IF, ...; exactly one resp per grant.
- DW addr 0x2000, wdata 0x11223344_55667788, wmask 0x0F, then DR 0x2000 over prior 0xFFFF..FF -> rdata 0xFFFFFFFF_55667788.
- DR with mem_rmiss=1 for 3 WAIT cycles -> resp_valid at N+6, err=0, mem_re held high N+1..N+5.
- mem_rmiss stuck high, MAX_RETRY=16 -> dr_resp_valid, err=1, rdata=0; mem_re drops; next request served normally.
- DR addr 0x1004 -> resp at N+2 with err=1, no mem_re; rst asserted in WAIT -> all outputs 0 immediately, no response.

Source files
------------

// File: rtl/orv64_mem_arbiter_pkg.sv
// Shared definitions for the orv64 memory-port arbiter.
//   orv64_param_pkg   : default retry budget.
//   orv64_typedef_pkg : requester ids, FSM states, latched request record.

package orv64_param_pkg;
    // Consecutive miss cycles tolerated before a request is aborted.
    localparam int ORV64_MARB_MAX_RETRY = 16;
endpackage

package orv64_typedef_pkg;
    typedef enum logic [1:0] {
        ORV64_MARB_SRC_IF = 2'd0,
        ORV64_MARB_SRC_DR = 2'd1,
        ORV64_MARB_SRC_DW = 2'd2
    } orv64_marb_src_e;

    typedef enum logic [1:0] {
        ORV64_MARB_IDLE  = 2'd0,
        ORV64_MARB_ISSUE = 2'd1,
        ORV64_MARB_WAIT  = 2'd2,
        ORV64_MARB_ERR   = 2'd3
    } orv64_marb_state_e;

    typedef struct packed {
        orv64_marb_src_e src;
        logic [63:0]     addr;
        logic [63:0]     wdata;
        logic [7:0]      wmask;
    } orv64_marb_req_t;
endpackage

// File: rtl/orv64_mem_arbiter_rr_arb3.sv
// 3-way round-robin pick, purely combinational.
//   valid : request vector, bit 0 = IF, bit 1 = DR, bit 2 = DW
//   ptr   : index of the requester that currently has highest priority
//   grant : one-hot winner (all zero when nothing is valid)

module orv64_rr_arb3 (
    input  logic [2:0] valid,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd0: grant = valid[0] ? 3'b001 : valid[1] ? 3'b010 : valid[2] ? 3'b100 : 3'b000;
            2'd1: grant = valid[1] ? 3'b010 : valid[2] ? 3'b100 : valid[0] ? 3'b001 : 3'b000;
            default: grant = valid[2] ? 3'b100 : valid[0] ? 3'b001 : valid[1] ? 3'b010 : 3'b000;
        endcase
    end

endmodule

// File: rtl/orv64_mem_arbiter.sv
// Single-outstanding arbiter sharing one 64-bit memory port among
// instruction fetch (IF), data read (DR) and data write (DW).
//   clk, rst          : clock, asynchronous active-high reset
//   if_req_* / if_resp_*  : fetch request (pc) and 32-bit instruction response
//   dr_req_* / dr_resp_*  : data read request and 64-bit read-data response
//   dw_req_* / dw_resp_*  : data write request (addr/wdata/wmask) and ack
//   mem_r* / mem_w*   : memory port, 1-cycle access with per-cycle miss flag
//
// state | meaning
// IDLE  | waiting for a request; ready of the round-robin winner asserted
// ISSUE | first cycle driving the access, retry budget reloaded
// WAIT  | access still driven; miss flag sampled, response or retry/abort
// ERR   | misaligned request, error response without memory access

module orv64_mem_arbiter
    import orv64_typedef_pkg::*;
    import orv64_param_pkg::*;
#(
    parameter int MAX_RETRY = ORV64_MARB_MAX_RETRY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [63:0] if_req_pc,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_inst,
    output logic        if_resp_err,
    input  logic        dr_req_valid,
    input  logic [63:0] dr_req_addr,
    output logic        dr_req_ready,
    output logic        dr_resp_valid,
    output logic [63:0] dr_resp_rdata,
    output logic        dr_resp_err,
    input  logic        dw_req_valid,
    input  logic [63:0] dw_req_addr,
    input  logic [63:0] dw_req_wdata,
    input  logic [7:0]  dw_req_wmask,
    output logic        dw_req_ready,
    output logic        dw_resp_valid,
    output logic        dw_resp_err,
    output logic        mem_re,
    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rmiss,
    output logic        mem_we,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_wmiss
);

    localparam int          CNT_W      = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [63:0] ALIGN_MASK = ~64'h7;

    orv64_marb_state_e state, state_nxt;
    orv64_marb_req_t   req_q, win_req;
    logic [1:0]        ptr_q, ptr_nxt;
    logic [CNT_W-1:0]  retry_cnt;
    logic [2:0]        grant;
    logic              fire, win_misaligned, is_read, miss;
    logic              wait_done, wait_abort, rsp_fire, rsp_err;
    logic [31:0]       if_word;

    orv64_rr_arb3 u_arb (
        .valid ({dw_req_valid, dr_req_valid, if_req_valid}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        win_req = '0;
        if (grant[0]) begin
            win_req.src  = ORV64_MARB_SRC_IF;
            win_req.addr = if_req_pc;
        end else if (grant[1]) begin
            win_req.src  = ORV64_MARB_SRC_DR;
            win_req.addr = dr_req_addr;
        end else if (grant[2]) begin
            win_req.src   = ORV64_MARB_SRC_DW;
            win_req.addr  = dw_req_addr;
            win_req.wdata = dw_req_wdata;
            win_req.wmask = dw_req_wmask;
        end
    end

    // Fetch needs 4-byte alignment, data accesses 8-byte alignment.
    assign win_misaligned = (win_req.src == ORV64_MARB_SRC_IF) ? (win_req.addr[1:0] != 2'b00)
                                                               : (win_req.addr[2:0] != 3'b000);
    assign fire       = (state == ORV64_MARB_IDLE) && (grant != 3'b000);
    assign ptr_nxt    = grant[0] ? 2'd1 : grant[1] ? 2'd2 : 2'd0;
    assign is_read    = (req_q.src != ORV64_MARB_SRC_DW);
    assign miss       = is_read ? mem_rmiss : mem_wmiss;
    // retry_cnt counts down the remaining tolerated misses; reaching zero on
    // a miss means this WAIT cycle is the MAX_RETRY-th consecutive miss.
    assign wait_done  = (state == ORV64_MARB_WAIT) && !miss;
    assign wait_abort = (state == ORV64_MARB_WAIT) && miss && (retry_cnt == '0);
    assign rsp_fire   = wait_done || wait_abort || (state == ORV64_MARB_ERR);
    assign rsp_err    = wait_abort || (state == ORV64_MARB_ERR);
    assign if_word    = req_q.addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ORV64_MARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ORV64_MARB_IDLE:  if (fire) state_nxt = win_misaligned ? ORV64_MARB_ERR : ORV64_MARB_ISSUE;
            ORV64_MARB_ISSUE: state_nxt = ORV64_MARB_WAIT;
            ORV64_MARB_WAIT:  if (wait_done || wait_abort) state_nxt = ORV64_MARB_IDLE;
            ORV64_MARB_ERR:   state_nxt = ORV64_MARB_IDLE;
            default:          state_nxt = ORV64_MARB_IDLE;
        endcase
    end

    always_comb begin
        if_req_ready = 1'b0;
        dr_req_ready = 1'b0;
        dw_req_ready = 1'b0;
        mem_re       = 1'b0;
        mem_raddr    = '0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        mem_wmask    = '0;
        // Ready is masked while reset is held so no handshake is advertised.
        if (state == ORV64_MARB_IDLE && !rst) begin
            if_req_ready = grant[0];
            dr_req_ready = grant[1];
            dw_req_ready = grant[2];
        end
        if (state == ORV64_MARB_ISSUE || state == ORV64_MARB_WAIT) begin
            if (is_read) begin
                mem_re    = 1'b1;
                mem_raddr = req_q.addr & ALIGN_MASK;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = req_q.addr & ALIGN_MASK;
                mem_wdata = req_q.wdata;
                mem_wmask = req_q.wmask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            ptr_q     <= 2'd2;
            retry_cnt <= '0;
        end else begin
            if (fire) begin
                req_q <= win_req;
                ptr_q <= ptr_nxt;
            end
            if (state == ORV64_MARB_ISSUE) begin
                retry_cnt <= CNT_W'(MAX_RETRY - 1);
            end else if (state == ORV64_MARB_WAIT && miss && retry_cnt != '0) begin
                retry_cnt <= retry_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_resp_valid <= 1'b0;
            if_resp_err   <= 1'b0;
            if_resp_inst  <= '0;
            dr_resp_valid <= 1'b0;
            dr_resp_err   <= 1'b0;
            dr_resp_rdata <= '0;
            dw_resp_valid <= 1'b0;
            dw_resp_err   <= 1'b0;
        end else begin
            if_resp_valid <= rsp_fire && (req_q.src == ORV64_MARB_SRC_IF);
            if_resp_err   <= rsp_fire && rsp_err && (req_q.src == ORV64_MARB_SRC_IF);
            if_resp_inst  <= (rsp_fire && !rsp_err && req_q.src == ORV64_MARB_SRC_IF) ? if_word : '0;
            dr_resp_valid <= rsp_fire && (req_q.src == ORV64_MARB_SRC_DR);
            dr_resp_err   <= rsp_fire && rsp_err && (req_q.src == ORV64_MARB_SRC_DR);
            dr_resp_rdata <= (rsp_fire && !rsp_err && req_q.src == ORV64_MARB_SRC_DR) ? mem_rdata : '0;
            dw_resp_valid <= rsp_fire && (req_q.src == ORV64_MARB_SRC_DW);
            dw_resp_err   <= rsp_fire && rsp_err && (req_q.src == ORV64_MARB_SRC_DW);
        end
    end

endmodule

// File: tb/tb_orv64_mem_arbiter.sv
// Directed bench for orv64_mem_arbiter with a small byte-masked memory model
// (registered read, write when mem_we and no miss).

module tb_orv64_mem_arbiter;

    logic        clk, rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [63:0] if_req_pc;
    logic [31:0] if_resp_inst;
    logic        dr_req_valid, dr_req_ready, dr_resp_valid, dr_resp_err;
    logic [63:0] dr_req_addr, dr_resp_rdata;
    logic        dw_req_valid, dw_req_ready, dw_resp_valid, dw_resp_err;
    logic [63:0] dw_req_addr, dw_req_wdata;
    logic [7:0]  dw_req_wmask;
    logic        mem_re, mem_rmiss, mem_we, mem_wmiss;
    logic [63:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;

    int vec;
    int errs;
    int n_if, n_dr, n_dw;

    logic [63:0] mem [0:8191];
    logic        pl_en;
    logic [63:0] pl_addr, pl_data, wbm;

    orv64_mem_arbiter #(.MAX_RETRY(16)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_pc(if_req_pc), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst), .if_resp_err(if_resp_err),
        .dr_req_valid(dr_req_valid), .dr_req_addr(dr_req_addr), .dr_req_ready(dr_req_ready),
        .dr_resp_valid(dr_resp_valid), .dr_resp_rdata(dr_resp_rdata), .dr_resp_err(dr_resp_err),
        .dw_req_valid(dw_req_valid), .dw_req_addr(dw_req_addr), .dw_req_wdata(dw_req_wdata),
        .dw_req_wmask(dw_req_wmask), .dw_req_ready(dw_req_ready),
        .dw_resp_valid(dw_resp_valid), .dw_resp_err(dw_resp_err),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rmiss(mem_rmiss),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wmiss(mem_wmiss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        wbm = '0;
        for (int b = 0; b < 8; b++) wbm[8*b +: 8] = {8{mem_wmask[b]}};
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[15:3]] <= pl_data;
        else if (mem_we && !mem_wmiss)
            mem[mem_waddr[15:3]] <= (mem[mem_waddr[15:3]] & ~wbm) | (mem_wdata & wbm);
        if (mem_re) mem_rdata <= mem[mem_raddr[15:3]];
    end

    always @(negedge clk) begin
        if (if_resp_valid) n_if++;
        if (dr_resp_valid) n_dr++;
        if (dw_resp_valid) n_dw++;
    end

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drop_all();
        if_req_valid = 1'b0; dr_req_valid = 1'b0; dw_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        if_req_valid = 1'b1; if_req_pc = 64'h100;
        dr_req_valid = 1'b1; dr_req_addr = 64'h108;
        dw_req_valid = 1'b1; dw_req_addr = 64'h200;
        #1;
        vec++;
        if ({if_req_ready, dr_req_ready, dw_req_ready, mem_re, mem_we} !== 5'b0) begin
            errs++; $display("FAIL reset_ctl got %b want 00000", {if_req_ready, dr_req_ready, dw_req_ready, mem_re, mem_we});
        end
        vec++;
        if ({if_resp_valid, if_resp_err, dr_resp_valid, dr_resp_err, dw_resp_valid, dw_resp_err} !== 6'b0) begin
            errs++; $display("FAIL reset_resp got %b want 000000", {if_resp_valid, if_resp_err, dr_resp_valid, dr_resp_err, dw_resp_valid, dw_resp_err});
        end
        vec++;
        if ((mem_raddr | mem_waddr | mem_wdata | {56'd0, mem_wmask} | {32'd0, if_resp_inst} | dr_resp_rdata) !== 64'd0) begin
            errs++; $display("FAIL reset_data got raddr=%h waddr=%h wdata=%h want all 0", mem_raddr, mem_waddr, mem_wdata);
        end
        drop_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rr_order();
        logic [2:0] exp_order [6];
        logic [2:0] r;
        int t, g, s_if, s_dr, s_dw;
        exp_order = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        s_if = n_if; s_dr = n_dr; s_dw = n_dw;
        if_req_valid = 1'b1; if_req_pc = 64'h100;
        dr_req_valid = 1'b1; dr_req_addr = 64'h108;
        dw_req_valid = 1'b1; dw_req_addr = 64'h200;
        dw_req_wdata = 64'hA5A5_A5A5_A5A5_A5A5; dw_req_wmask = 8'hFF;
        t = 0; g = 0;
        while (g < 6 && t < 40) begin
            #1;
            r = {dw_req_ready, dr_req_ready, if_req_ready};
            if (r != 3'b000) begin
                vec++;
                if (r !== exp_order[g] || t != 3 * g) begin
                    errs++; $display("FAIL rr_grant%0d got %b at cycle %0d want %b at cycle %0d", g, r, t, exp_order[g], 3 * g);
                end
                g++;
            end
            @(negedge clk);
            t++;
        end
        vec++;
        if (g != 6) begin
            errs++; $display("FAIL rr_timeout got %0d grants want 6", g);
        end
        drop_all();
        repeat (4) @(negedge clk);
        vec++;
        if (n_if - s_if != 2 || n_dr - s_dr != 2 || n_dw - s_dw != 2) begin
            errs++; $display("FAIL rr_resp_count got if=%0d dr=%0d dw=%0d want 2 each", n_if - s_if, n_dr - s_dr, n_dw - s_dw);
        end
    endtask

    task automatic test_if_fetch();
        preload(64'h1000, 64'hDEADBEEF_00000013);
        if_req_valid = 1'b1; if_req_pc = 64'h1004;
        #1;
        vec++;
        if (if_req_ready !== 1'b1) begin
            errs++; $display("FAIL if_ready got %b want 1", if_req_ready);
        end
        @(negedge clk);
        if_req_valid = 1'b0;
        #1;
        vec++;
        if (mem_re !== 1'b1 || mem_raddr !== 64'h1000 || mem_we !== 1'b0) begin
            errs++; $display("FAIL if_issue got re=%b raddr=%h we=%b want 1 1000 0", mem_re, mem_raddr, mem_we);
        end
        @(negedge clk);
        #1;
        vec++;
        if (if_resp_valid !== 1'b0) begin
            errs++; $display("FAIL if_early_resp got %b want 0", if_resp_valid);
        end
        @(negedge clk);
        #1;
        vec++;
        if (if_resp_valid !== 1'b1 || if_resp_inst !== 32'hDEADBEEF || if_resp_err !== 1'b0) begin
            errs++; $display("FAIL if_resp got v=%b inst=%h err=%b want 1 deadbeef 0", if_resp_valid, if_resp_inst, if_resp_err);
        end
        @(negedge clk);
        #1;
        vec++;
        if (if_resp_valid !== 1'b0) begin
            errs++; $display("FAIL if_pulse got %b want 0", if_resp_valid);
        end
    endtask

    task automatic test_write_read();
        preload(64'h2000, 64'hFFFF_FFFF_FFFF_FFFF);
        dw_req_valid = 1'b1; dw_req_addr = 64'h2000;
        dw_req_wdata = 64'h11223344_55667788; dw_req_wmask = 8'h0F;
        #1;
        vec++;
        if (dw_req_ready !== 1'b1) begin
            errs++; $display("FAIL dw_ready got %b want 1", dw_req_ready);
        end
        @(negedge clk);
        dw_req_valid = 1'b0;
        #1;
        vec++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_waddr !== 64'h2000 || mem_wdata !== 64'h11223344_55667788 || mem_wmask !== 8'h0F) begin
            errs++; $display("FAIL dw_issue got we=%b re=%b waddr=%h wdata=%h wmask=%h", mem_we, mem_re, mem_waddr, mem_wdata, mem_wmask);
        end
        repeat (2) @(negedge clk);
        dr_req_valid = 1'b1; dr_req_addr = 64'h2000;
        #1;
        vec++;
        if (dw_resp_valid !== 1'b1 || dw_resp_err !== 1'b0) begin
            errs++; $display("FAIL dw_resp got v=%b err=%b want 1 0", dw_resp_valid, dw_resp_err);
        end
        vec++;
        if (dr_req_ready !== 1'b1) begin
            errs++; $display("FAIL dr_ready_with_resp got %b want 1", dr_req_ready);
        end
        @(negedge clk);
        dr_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (dr_resp_valid !== 1'b1 || dr_resp_rdata !== 64'hFFFFFFFF_55667788 || dr_resp_err !== 1'b0) begin
            errs++; $display("FAIL dr_after_write got v=%b rdata=%h err=%b want 1 ffffffff55667788 0", dr_resp_valid, dr_resp_rdata, dr_resp_err);
        end
    endtask

    task automatic test_read_miss();
        preload(64'h3000, 64'h01234567_89ABCDEF);
        dr_req_valid = 1'b1; dr_req_addr = 64'h3000;
        #1;
        vec++;
        if (dr_req_ready !== 1'b1) begin
            errs++; $display("FAIL miss_ready got %b want 1", dr_req_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            dr_req_valid = 1'b0;
            mem_rmiss = (c >= 2 && c <= 4);
            #1;
            if (c <= 5) begin
                vec++;
                if (mem_re !== 1'b1 || dr_resp_valid !== 1'b0) begin
                    errs++; $display("FAIL miss_hold%0d got re=%b v=%b want 1 0", c, mem_re, dr_resp_valid);
                end
            end else begin
                vec++;
                if (dr_resp_valid !== 1'b1 || dr_resp_err !== 1'b0 || dr_resp_rdata !== 64'h01234567_89ABCDEF || mem_re !== 1'b0) begin
                    errs++; $display("FAIL miss_resp got v=%b err=%b rdata=%h re=%b", dr_resp_valid, dr_resp_err, dr_resp_rdata, mem_re);
                end
            end
        end
    endtask

    task automatic test_retry_abort();
        int rc, re_cnt;
        logic e, re_at;
        logic [63:0] d;
        rc = 0; re_cnt = 0; e = 1'b0; re_at = 1'b1; d = '1;
        mem_rmiss = 1'b1;
        dr_req_valid = 1'b1; dr_req_addr = 64'h3000;
        #1;
        vec++;
        if (dr_req_ready !== 1'b1) begin
            errs++; $display("FAIL abort_ready got %b want 1", dr_req_ready);
        end
        for (int c = 1; c <= 30 && rc == 0; c++) begin
            @(negedge clk);
            dr_req_valid = 1'b0;
            #1;
            if (dr_resp_valid) begin
                rc = c; e = dr_resp_err; d = dr_resp_rdata; re_at = mem_re;
            end else if (mem_re) begin
                re_cnt++;
            end
        end
        vec++;
        if (rc != 18) begin
            errs++; $display("FAIL abort_cycle got %0d want 18", rc);
        end
        vec++;
        if (e !== 1'b1 || d !== 64'd0 || re_at !== 1'b0) begin
            errs++; $display("FAIL abort_resp got err=%b rdata=%h re=%b want 1 0 0", e, d, re_at);
        end
        vec++;
        if (re_cnt != 17) begin
            errs++; $display("FAIL abort_re_cycles got %0d want 17", re_cnt);
        end
        mem_rmiss = 1'b0;
        dr_req_valid = 1'b1; dr_req_addr = 64'h3000;
        #1;
        vec++;
        if (dr_req_ready !== 1'b1) begin
            errs++; $display("FAIL abort_next_ready got %b want 1", dr_req_ready);
        end
        @(negedge clk);
        dr_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (dr_resp_valid !== 1'b1 || dr_resp_err !== 1'b0 || dr_resp_rdata !== 64'h01234567_89ABCDEF) begin
            errs++; $display("FAIL abort_next_resp got v=%b err=%b rdata=%h", dr_resp_valid, dr_resp_err, dr_resp_rdata);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0] oh;
        for (int s = 0; s < 3; s++) begin
            oh = 3'b001 << s;
            if_req_valid = (s == 0); if_req_pc = 64'h1002;
            dr_req_valid = (s == 1); dr_req_addr = 64'h1004;
            dw_req_valid = (s == 2); dw_req_addr = 64'h2004;
            dw_req_wdata = '1; dw_req_wmask = 8'hFF;
            #1;
            vec++;
            if ({dw_req_ready, dr_req_ready, if_req_ready} !== oh) begin
                errs++; $display("FAIL mis%0d_ready got %b want %b", s, {dw_req_ready, dr_req_ready, if_req_ready}, oh);
            end
            @(negedge clk);
            drop_all();
            #1;
            vec++;
            if ({mem_re, mem_we} !== 2'b00) begin
                errs++; $display("FAIL mis%0d_access got re=%b we=%b want 0 0", s, mem_re, mem_we);
            end
            @(negedge clk);
            #1;
            vec++;
            if ({dw_resp_valid, dr_resp_valid, if_resp_valid} !== oh || {dw_resp_err, dr_resp_err, if_resp_err} !== oh
                || if_resp_inst !== 32'd0 || dr_resp_rdata !== 64'd0) begin
                errs++; $display("FAIL mis%0d_resp got v=%b err=%b inst=%h rdata=%h want v=err=%b data 0", s,
                                 {dw_resp_valid, dr_resp_valid, if_resp_valid}, {dw_resp_err, dr_resp_err, if_resp_err},
                                 if_resp_inst, dr_resp_rdata, oh);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int s_dr, s_dw;
        s_dr = n_dr; s_dw = n_dw;
        mem_rmiss = 1'b1;
        dr_req_valid = 1'b1; dr_req_addr = 64'h3000;
        @(negedge clk);
        dr_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if (mem_re !== 1'b1) begin
            errs++; $display("FAIL rstw_pre got re=%b want 1", mem_re);
        end
        if_req_valid = 1'b1; if_req_pc = 64'h100;
        dr_req_valid = 1'b1; dr_req_addr = 64'h3000;
        dw_req_valid = 1'b1; dw_req_addr = 64'h400;
        dw_req_wdata = 64'h55; dw_req_wmask = 8'h01;
        rst = 1'b1;
        #1;
        vec++;
        if ({if_req_ready, dr_req_ready, dw_req_ready, mem_re, mem_we, if_resp_valid, dr_resp_valid, dw_resp_valid} !== 8'b0
            || mem_raddr !== 64'd0 || mem_waddr !== 64'd0) begin
            errs++; $display("FAIL rstw_zero got ctl=%b raddr=%h waddr=%h want all 0",
                             {if_req_ready, dr_req_ready, dw_req_ready, mem_re, mem_we, if_resp_valid, dr_resp_valid, dw_resp_valid},
                             mem_raddr, mem_waddr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_rmiss = 1'b0;
        #1;
        vec++;
        if ({dw_req_ready, dr_req_ready, if_req_ready} !== 3'b100) begin
            errs++; $display("FAIL rstw_ptr got %b want 100", {dw_req_ready, dr_req_ready, if_req_ready});
        end
        @(negedge clk);
        drop_all();
        repeat (5) @(negedge clk);
        vec++;
        if (n_dr != s_dr || n_dw != s_dw + 1) begin
            errs++; $display("FAIL rstw_resp got dr=%0d dw=%0d want dr=0 dw=1", n_dr - s_dr, n_dw - s_dw);
        end
    endtask

    initial begin
        vec = 0; errs = 0; n_if = 0; n_dr = 0; n_dw = 0;
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_pc = '0;
        dr_req_valid = 1'b0; dr_req_addr = '0;
        dw_req_valid = 1'b0; dw_req_addr = '0; dw_req_wdata = '0; dw_req_wmask = '0;
        mem_rmiss = 1'b0; mem_wmiss = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_rr_order();
        test_if_fetch();
        test_write_read();
        test_read_miss();
        test_retry_abort();
        test_misaligned();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
